fetch_sequencer: RTL and testbench

Instruction-fetch controller for the pipelined processor. It owns the program counter and drives the address input of the combinational, byte-addressed, little-endian instruction memory. Fetched words go into a small prefetch buffer that feeds the decode stage through a valid/ready handshake. The block also applies branch redirects from the execute stage and stops fetching cleanly at the end of the loaded program image.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: NOP encoding, FSM states and
// the prefetch buffer entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [63:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush (beats push) and push-on-full
// allowed when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, prefetch buffer, redirects, end-of-image halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 672,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic        halt,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

  fetch_state_e state;
  logic [63:0]  pc;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         in_image;
  logic         fetch;
  logic         push;
  logic         redir_take;
  logic         redir_bad;

  assign if_valid   = !fifo_empty;
  assign pop        = if_valid && id_ready;
  assign in_image   = (pc <= LAST_PC);
  assign redir_take = redirect_valid && (state != FAULT);
  assign redir_bad  = redir_take && !is_aligned(redirect_pc);
  assign fetch      = (state == RUN) && in_image && (!fifo_full || pop);
  // A redirect kills the fetch of the same cycle along with the buffer.
  assign push       = fetch && !redir_take;
  assign push_data  = '{pc: pc, inst: imem_inst};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir_take),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (redir_take) begin
      if (redir_bad) begin
        state <= FAULT;
      end else begin
        pc    <= redirect_pc;
        state <= RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (fetch)          pc    <= pc + 64'd4;
          else if (!in_image) state <= HALTED;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign if_inst   = if_valid ? head.inst : NOP_INST;
  assign if_pc     = if_valid ? head.pc   : 64'h0;
  assign halt      = (state == HALTED) && fifo_empty;
  assign fault     = (state == FAULT);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        bubble;

  assign bubble = id_ready && !if_valid && (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (pop && (fetch_cnt_q != 32'hFFFF_FFFF))     fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  assign fetch_count  = 32'h0;
  assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for reset/stall/redirect,
// hand-written sequences for end-of-image, fault and the perf counters.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        halt;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Standard program image (672 bytes); anything beyond it must never be fetched.
  function automatic logic [31:0] img(input logic [63:0] a);
    if (a > 64'h29C) return 32'hDEAD_BEEF;
    case (a)
      64'h000: return 32'h0000_0013;
      64'h010: return 32'h0090_0413;
      64'h180: return 32'h0489_0263;
      default: return {a[13:2], 20'h00093};
    endcase
  endfunction

  assign imem_inst = img(imem_addr);

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .halt           (halt),
    .fault          (fault),
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] addr;
    logic        halt;
    logic        fault;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic rdy, input logic rv,
                              input logic [63:0] rpc, input logic valid,
                              input logic [63:0] pc, input logic [63:0] addr);
    vec_t v;
    v.rst   = rst;
    v.rdy   = rdy;
    v.rv    = rv;
    v.rpc   = rpc;
    v.valid = valid;
    v.pc    = valid ? pc : 64'h0;
    v.inst  = valid ? img(pc) : 32'h0000_0013;
    v.addr  = addr;
    v.halt  = 1'b0;
    v.fault = 1'b0;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        done;
    logic        gap;
    logic        halt_after_last;
    logic        pre_v;
    logic [63:0] pre_pc;
    logic [63:0] exp_next;
    logic [63:0] last_pc;
    int          bad;

    reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset, first fetch, steady stream.
    add(1, 0, 0, 0,       0, 0,      0);
    add(0, 0, 0, 0,       1, 0,      64'h4);
    add(0, 1, 0, 0,       1, 64'h4,  64'h8);
    add(0, 1, 0, 0,       1, 64'h8,  64'hC);
    add(0, 1, 0, 0,       1, 64'hC,  64'h10);
    add(0, 1, 0, 0,       1, 64'h10, 64'h14);
    // Stall fills the buffer, PC freezes at 0x8, release with no gaps.
    add(1, 0, 0, 0,       0, 0,      0);
    add(0, 0, 0, 0,       1, 0,      64'h4);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 64'h8);
    add(0, 1, 0, 0,       1, 64'h4,  64'hC);
    add(0, 1, 0, 0,       1, 64'h8,  64'h10);
    add(0, 1, 0, 0,       1, 64'hC,  64'h14);
    // Redirect with a full buffer, then redirect together with a pop.
    add(1, 0, 0, 0,       0, 0,      0);
    add(0, 0, 0, 0,       1, 0,      64'h4);
    add(0, 0, 0, 0,       1, 0,      64'h8);
    add(0, 0, 1, 64'h180, 0, 0,      64'h180);
    add(0, 0, 0, 0,       1, 64'h180, 64'h184);
    add(0, 1, 0, 0,       1, 64'h184, 64'h188);
    add(0, 1, 1, 64'h40,  0, 0,      64'h40);
    add(0, 1, 0, 0,       1, 64'h40, 64'h44);
    add(0, 1, 0, 0,       1, 64'h44, 64'h48);

    foreach (tbl[i]) begin
      reset          = tbl[i].rst;
      id_ready       = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      step();
      chk($sformatf("vec%0d.if_valid", i),  if_valid,  tbl[i].valid);
      chk($sformatf("vec%0d.if_pc", i),     if_pc,     tbl[i].pc);
      chk($sformatf("vec%0d.if_inst", i),   if_inst,   tbl[i].inst);
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d.halt", i),      halt,      tbl[i].halt);
      chk($sformatf("vec%0d.fault", i),     fault,     tbl[i].fault);
    end
    redirect_valid = 1'b0;

    // Run the whole image from reset down to the halt.
    reset = 1'b1; id_ready = 1'b0; step();
    reset = 1'b0; step();
    id_ready = 1'b1;
    done = 1'b0; gap = 1'b0; halt_after_last = 1'b0;
    exp_next = 64'h0; last_pc = '1;
    for (int i = 0; i < 400 && !done; i++) begin
      pre_v  = if_valid;
      pre_pc = if_pc;
      step();
      if (pre_v) begin
        if (pre_pc !== exp_next) gap = 1'b1;
        exp_next = pre_pc + 64'd4;
        last_pc  = pre_pc;
      end
      if (halt === 1'b1) begin
        done = 1'b1;
        halt_after_last = pre_v && (pre_pc == 64'h29C);
      end
    end
    chk("eoi.halt_reached",  done, 1'b1);
    chk("eoi.last_pc",       last_pc, 64'h29C);
    chk("eoi.no_gap",        gap, 1'b0);
    chk("eoi.halt_timing",   halt_after_last, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_addr !== 64'h2A0 || halt !== 1'b1 || if_valid !== 1'b0) bad++;
      step();
    end
    chk("eoi.parked_cycles_bad", 64'(bad), 64'h0);
    redirect_valid = 1'b1; redirect_pc = 64'h0; step();
    redirect_valid = 1'b0;
    chk("eoi.redir.halt",      halt, 1'b0);
    chk("eoi.redir.imem_addr", imem_addr, 64'h0);
    step();
    chk("eoi.resume.if_valid", if_valid, 1'b1);
    chk("eoi.resume.if_pc",    if_pc, 64'h0);

    // Misaligned redirect: sticky fault until reset, later redirects ignored.
    reset = 1'b1; id_ready = 1'b0; step();
    reset = 1'b0; step();
    redirect_valid = 1'b1; redirect_pc = 64'h102; step();
    chk("fault.fault",     fault, 1'b1);
    chk("fault.if_valid",  if_valid, 1'b0);
    chk("fault.imem_addr", imem_addr, 64'h4);
    redirect_valid = 1'b0; id_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 10);
      redirect_pc    = 64'h40;
      step();
      if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'h4 || halt !== 1'b0) bad++;
    end
    redirect_valid = 1'b0;
    chk("fault.sticky_cycles_bad", 64'(bad), 64'h0);
    reset = 1'b1; step();
    chk("fault.reset.fault", fault, 1'b0);
    reset = 1'b0; step();
    chk("fault.after.if_valid", if_valid, 1'b1);
    chk("fault.after.if_pc",    if_pc, 64'h0);
    chk("fault.after.fault",    fault, 1'b0);

    // Performance counters.
    reset = 1'b1; id_ready = 1'b0; step();
    chk("perf.reset.fetch_count",  fetch_count, 32'h0);
    chk("perf.reset.bubble_count", bubble_count, 32'h0);
    reset = 1'b0; step();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("perf.run.fetch_count",  fetch_count,  PERF ? 32'd10 : 32'd0);
    chk("perf.run.bubble_count", bubble_count, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h40; step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("perf.redir.fetch_count",  fetch_count,  PERF ? 32'd12 : 32'd0);
    chk("perf.redir.bubble_count", bubble_count, PERF ? 32'd1  : 32'd0);
    chk("perf.redir.if_pc",        if_pc, 64'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
